trace_capture_buffer: RTL and testbench
=======================================

# trace_capture_buffer

Synthesizable, parametrised trace recorder for the MIPS core's debug path. It samples a WIDTH-bit trace word (e.g. instruction word, PC, register value) during a bounded capture window. Each accepted sample is tagged with a 32-bit cycle timestamp and stored in a DEPTH-entry FIFO. Entries drain through a valid/ready read port, so trace logging works on hardware as well as in simulation.

## Interface
- WIDTH, 32, trace word width
- DEPTH, 64, FIFO entries; power of two, ≥ 2
- STOP_CYCLE, 1545, capture-window length in cycles; the window ends after the cycle whose timestamp equals STOP_CYCLE
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that opens a capture window
- stop  in  1  forces an early end of the window
- mode  in  1  0 = change-detect, 1 = every valid cycle
- din_valid  in  1  din qualifier
- din  in  WIDTH  trace word
- rd_ready  in  1  consumer accepts the head entry
- rd_valid  out  1  FIFO non-empty
- rd_data  out  WIDTH  head entry trace word
- rd_stamp  out  32  head entry timestamp
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- capturing  out  1  state == CAPTURE
- done  out  1  state == DONE

## Operation
- States: IDLE, CAPTURE, DONE.
- Reset (async, rst_n low):
  - state = IDLE
  - FIFO empty; rd/wr pointers = 0
  - count = 0, rd_valid = 0, overflow = 0, capturing = 0, done = 0
  - cycle counter = 0; last-captured register = 0; first-flag = 1
  - rd_data and rd_stamp show mem[0] (contents undefined; qualified by rd_valid).
- Transitions:
  - IDLE → CAPTURE on start.
  - DONE → CAPTURE on start.
  - CAPTURE → DONE when stop = 1, or when cycle == STOP_CYCLE.
  - start in CAPTURE is ignored.
- Entering CAPTURE:
  - clears cycle counter, FIFO pointers, count and overflow
  - sets first-flag
  - discards unread entries.
- Cycle counter: in CAPTURE, increments by 1 every clock and wraps at 2^32. The first CAPTURE cycle has timestamp 0.
- Capture condition, evaluated each CAPTURE cycle including the terminating cycle:
  - mode 1: din_valid = 1.
  - mode 0: din_valid = 1 and (first-flag = 1 or din ≠ last-captured).
- Accepted sample:
  - writes {cycle, din} at the write pointer
  - updates last-captured to din
  - clears first-flag.
- A qualifying sample is accepted when the FIFO is not full. It is also accepted when the FIFO is full and a read pops in the same cycle.
- When full with no pop, the sample is dropped, overflow is set and last-captured is not updated.
- Read port:
  - show-ahead: rd_data and rd_stamp present the head entry whenever rd_valid = 1
  - pop occurs on rd_valid & rd_ready
  - reads are allowed in every state, so draining continues in DONE and IDLE.
- Occupancy:
  - count = pushes − pops; it is unchanged on a simultaneous push and pop
  - pointers wrap modulo DEPTH.
- Samples in IDLE or DONE are ignored, and overflow is not affected.

## Timing
- Write latency: a sample accepted at edge N appears on rd_valid / rd_data after edge N (visible in cycle N+1) when the FIFO was empty.
- Read: a pop at edge N advances the head; the next entry is visible in cycle N+1 with no bubble.
- Window end: the sample in the cycle where stop = 1, or where cycle == STOP_CYCLE, is still captured. done = 1 from the following cycle.
- Start: the first capturable cycle is the one after the start edge.
- A start pulse coinciding with a pop in DONE: the clear takes priority and the pop is discarded.
- Reset asserted mid-capture or mid-drain: immediate return to reset values; no partial entry is retained.

## Test plan
- Mode 1, DEPTH = 8, STOP_CYCLE = 5: pulse start, hold din_valid = 1 with din = 0x100 + cycle.
  - Required: 6 entries, stamps 0..5, data 0x100..0x105.
  - done = 1 in the cycle after stamp 5; rd_ready = 1 drains them in order.
- Mode 0: din sequence A, A, B, B, B, A, with din_valid = 1 throughout.
  - Required: exactly 3 entries, A@0, B@2, A@5.
- Overflow, DEPTH = 4, mode 1, rd_ready = 0, 6 valid cycles.
  - Required: count = 4, overflow = 1, stored stamps 0..3.
- Full FIFO with simultaneous push and pop.
  - Required: the push is accepted, count stays 4, overflow stays 0.
- stop asserted in cycle 2 of the window with STOP_CYCLE = 1545.
  - Required: entries with stamps 0..2; subsequent din is ignored.
- rst_n dropped mid-capture with count = 3.
  - Required: immediately count = 0, rd_valid = 0, state IDLE.
  - A new start restarts stamps at 0.

Source files
------------

// File: rtl/trace_capture_buffer.sv
// Windowed trace recorder: samples din during a capture window, tags each accepted
// sample with a cycle timestamp and queues {stamp, data} in a show-ahead FIFO.
module trace_capture_buffer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int STOP_CYCLE = 1545
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic                   din_valid,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [31:0]            rd_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   capturing,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [31:0]    r_cycle;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           r_overflow;
  logic           r_first;
  logic [WIDTH-1:0] r_last;

  logic [WIDTH-1:0] r_mem_data  [DEPTH];
  logic [31:0]      r_mem_stamp [DEPTH];

  logic w_restart;
  logic w_window_end;
  logic w_qualify;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A start outside CAPTURE wipes the FIFO, so it also cancels any pop in that cycle.
  assign w_restart    = start && (r_state != S_CAPTURE);
  assign w_window_end = (r_state == S_CAPTURE) && (stop || (r_cycle == 32'(STOP_CYCLE)));
  assign w_qualify    = (r_state == S_CAPTURE) && din_valid && (mode || r_first || (din != r_last));
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_pop        = rd_valid && rd_ready && !w_restart;
  assign w_push       = w_qualify && (!w_full || w_pop);
  assign w_drop       = w_qualify && w_full && !w_pop;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_next = S_CAPTURE;
      S_CAPTURE:      if (w_window_end) w_state_next = S_DONE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_first    <= 1'b1;
      r_last     <= '0;
    end else if (w_restart) begin
      r_cycle    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_first    <= 1'b1;
    end else begin
      if (r_state == S_CAPTURE) r_cycle <= r_cycle + 32'd1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_last   <= din;
        r_first  <= 1'b0;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= din;
      r_mem_stamp[r_wr_ptr] <= r_cycle;
    end
  end

  assign rd_valid  = (r_count != '0);
  assign rd_data   = r_mem_data[r_rd_ptr];
  assign rd_stamp  = r_mem_stamp[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign capturing = (r_state == S_CAPTURE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed plus random bench for trace_capture_buffer, checked every cycle against a
// queue-based reference model of the capture window.
module tb_trace_capture_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int STOP  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, mode, din_valid, rd_ready;
  logic [WIDTH-1:0] din;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [31:0]      rd_stamp;
  logic [$clog2(DEPTH):0] count;
  logic             overflow, capturing, done;

  trace_capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STOP_CYCLE(STOP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .din_valid(din_valid), .din(din), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_stamp(rd_stamp), .count(count), .overflow(overflow),
    .capturing(capturing), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: window phase, timestamp, change-detect memory and an entry queue.
  int          m_phase;   // 0 idle, 1 capturing, 2 done
  logic [31:0] m_cyc;
  bit          m_first, m_ovf;
  logic [WIDTH-1:0] m_last;
  logic [63:0] m_q[$];
  logic [63:0] obs_log[$];
  logic [63:0] exp_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cyc = 0; m_first = 1; m_ovf = 0; m_last = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop, qual;
    pop = (m_q.size() != 0) && rd_ready;
    if (m_phase != 1 && start) begin
      m_q.delete(); m_cyc = 0; m_ovf = 0; m_first = 1; m_phase = 1;
    end else if (m_phase == 1) begin
      qual = din_valid && (mode || m_first || din != m_last);
      if (pop) void'(m_q.pop_front());
      if (qual) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({m_cyc, din}); m_last = din; m_first = 0;
        end else m_ovf = 1;
      end
      if (stop || m_cyc == STOP) m_phase = 2;
      m_cyc = m_cyc + 1;
    end else if (pop) begin
      void'(m_q.pop_front());
    end
  endtask

  task automatic check_all();
    chk("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("capturing", 64'(capturing), 64'(m_phase == 1));
    chk("done", 64'(done), 64'(m_phase == 2));
    if (m_q.size() != 0) chk("head", {rd_stamp, rd_data}, m_q[0]);
  endtask

  task automatic tick();
    if (rd_valid && rd_ready) obs_log.push_back({rd_stamp, rd_data});
    @(posedge clk); #1;
    if (rst_n) model_step();
    check_all();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 64'(obs_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < obs_log.size(); i++)
      chk(tag, obs_log[i], exp_log[i]);
    obs_log.delete(); exp_log.delete();
  endtask

  task automatic open_window(input logic m);
    start = 1; mode = m; din_valid = 0; stop = 0; tick(); start = 0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1; din_valid = 0;
    for (int i = 0; i < n; i++) tick();
    rd_ready = 0;
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    rst_n = 0; start = 0; stop = 0; mode = 0; din_valid = 0; rd_ready = 0; din = '0;
    model_reset();
    #3 check_all();
    @(posedge clk); #1 rst_n = 1;
    tick();

    // Mode 1 full window with continuous drain.
    rd_ready = 1; open_window(1);
    for (int i = 0; i < 6; i++) begin din_valid = 1; din = 32'h100 + i; tick(); end
    chk("t1_done", 64'(done), 64'd1);
    din_valid = 1; din = 32'hdead; tick(); tick();
    for (int i = 0; i < 6; i++) exp_log.push_back({32'(i), 32'h100 + 32'(i)});
    check_log("t1_entry");

    // Change-detect: A A B B B A.
    a = 32'haaaa_0001; b = 32'hbbbb_0002;
    rd_ready = 0; open_window(0);
    for (int i = 0; i < 6; i++) begin
      din_valid = 1; din = (i >= 2 && i <= 4) ? b : a; tick();
    end
    chk("t2_count", 64'(count), 64'd3);
    drain(4);
    exp_log.push_back({32'd0, a}); exp_log.push_back({32'd2, b}); exp_log.push_back({32'd5, a});
    check_log("t2_entry");

    // Overflow with no reads.
    open_window(1);
    for (int i = 0; i < 6; i++) begin din_valid = 1; din = $urandom; tick(); end
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_ovf", 64'(overflow), 64'd1);
    drain(5);
    for (int i = 0; i < 4; i++) exp_log.push_back({32'(i), m_q.size() == 0 ? 32'h0 : 32'h0});
    for (int i = 0; i < obs_log.size(); i++) obs_log[i][31:0] = '0;
    check_log("t3_stamp");

    // Full FIFO with simultaneous push and pop.
    open_window(1);
    for (int i = 0; i < 4; i++) begin din_valid = 1; din = 32'h200 + i; tick(); end
    din = 32'h204; rd_ready = 1; tick();
    chk("t4_count", 64'(count), 64'd4);
    chk("t4_ovf", 64'(overflow), 64'd0);
    rd_ready = 0; din_valid = 0; tick();
    obs_log.delete();
    drain(5);
    for (int i = 1; i < 5; i++) exp_log.push_back({32'(i), 32'h200 + 32'(i)});
    check_log("t4_entry");

    // Early stop in cycle 2 of the window.
    open_window(1);
    for (int i = 0; i < 6; i++) begin
      din_valid = 1; din = 32'h300 + i; stop = (i == 2); tick();
    end
    stop = 0;
    chk("t5_count", 64'(count), 64'd3);
    drain(4);
    for (int i = 0; i < 3; i++) exp_log.push_back({32'(i), 32'h300 + 32'(i)});
    check_log("t5_entry");

    // Reset mid-capture with three entries held.
    open_window(1);
    for (int i = 0; i < 3; i++) begin din_valid = 1; din = 32'h400 + i; tick(); end
    #2 rst_n = 0;
    #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(rd_valid), 64'd0);
    chk("t6_capturing", 64'(capturing), 64'd0);
    model_reset();
    check_all();
    #1 rst_n = 1;
    open_window(1);
    din_valid = 1; din = 32'h500; tick();
    chk("t6_restamp", 64'(rd_stamp), 64'd0);
    din_valid = 0; drain(2); obs_log.delete();

    // Random traffic, including starts during capture and starts colliding with pops.
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      mode      = $urandom_range(0, 1);
      din_valid = ($urandom_range(0, 3) != 0);
      din       = $urandom_range(0, 3);
      rd_ready  = $urandom_range(0, 1);
      tick();
    end
    obs_log.delete();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
